// File: rtl/fringe_seq_gen.sv
`default_nettype none
// ============================================================================
// Module   : fringe_seq_gen
// Brief    : Structured-light fringe sequencer with camera handshake and
//            per-line phase accumulator. Optional build macro:
//            FRINGE_REF_FRAMES_EN (white/black reference frames before fringes).
// Revision : 1.0 - initial release
// ============================================================================
module fringe_seq_gen #(
    parameter int unsigned     PW            = 32,
    parameter int unsigned     OW            = 10,
    parameter int unsigned     NSTEP         = 8,
    parameter int unsigned     NFREQ         = 4,
    parameter logic [PW-1:0]   PINC0         = 32'h2000_0000,
    parameter int unsigned     SETTLE_FRAMES = 2,
    parameter int unsigned     TRIG_W        = 4
) (
    input  logic                                         clk_25,
    input  logic                                         reset_n,
    input  logic                                         frame_stb,
    input  logic                                         row_stb,
    input  logic                                         line_stb,
    input  logic                                         trig_in,
    input  logic                                         rdy_in,
    output logic                                         cam_trig,
    output logic                                         seq_busy,
    output logic                                         done,
    output logic [$clog2(NSTEP)-1:0]                     shift_idx,
    output logic [((NFREQ > 1) ? $clog2(NFREQ) : 1)-1:0] freq_idx,
    output logic [OW-1:0]                                phase_out,
    output logic [1:0]                                   pix_force
);

    localparam int unsigned c_sw = $clog2(NSTEP);
    localparam int unsigned c_fw = (NFREQ > 1) ? $clog2(NFREQ) : 1;
    localparam int unsigned c_cw = (SETTLE_FRAMES > 1) ? $clog2(SETTLE_FRAMES) : 1;
    localparam int unsigned c_tw = (TRIG_W > 1) ? $clog2(TRIG_W) : 1;

    localparam logic [c_sw-1:0] c_shift_last  = c_sw'(NSTEP - 1);
    localparam logic [c_fw-1:0] c_freq_last   = c_fw'(NFREQ - 1);
    localparam logic [c_cw-1:0] c_settle_last = c_cw'(SETTLE_FRAMES - 1);
    localparam logic [c_tw-1:0] c_tcnt_load   = c_tw'(TRIG_W - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SETTLE    = 3'd1,
        ST_EXPOSE    = 3'd2,
        ST_DONE      = 3'd3
`ifdef FRINGE_REF_FRAMES_EN
        ,
        ST_REF_WHITE = 3'd4,
        ST_REF_BLACK = 3'd5
`endif
    } state_t;

    logic            r_trig_meta_q, r_trig_s_q;
    logic            r_rdy_meta_q,  r_rdy_s_q;

    state_t          r_state_q,  w_state_d;
    logic [c_cw-1:0] r_settle_q, w_settle_d;
    logic [c_sw-1:0] r_shift_q,  w_shift_d;
    logic [c_fw-1:0] r_freq_q,   w_freq_d;
    logic            r_done_q,   w_done_d;
    logic            r_cam_q,    w_cam_d;
    logic [c_tw-1:0] r_tcnt_q,   w_tcnt_d;
    logic            w_fire;
`ifdef FRINGE_REF_FRAMES_EN
    logic [1:0]      r_pix_q,    w_pix_d;
`endif

    logic [PW-1:0]   r_acc_q,    w_acc_d;
    logic [OW-1:0]   r_phase_q,  w_phase_d;
    logic [PW-1:0]   w_pinc;
    logic [PW-1:0]   w_poff;

    // Sequencer next-state; a low synced trigger overrides everything else.
    always_comb begin
        w_state_d  = r_state_q;
        w_settle_d = r_settle_q;
        w_shift_d  = r_shift_q;
        w_freq_d   = r_freq_q;
        w_done_d   = r_done_q;
        w_fire     = 1'b0;
`ifdef FRINGE_REF_FRAMES_EN
        w_pix_d    = r_pix_q;
`endif
        if (!r_trig_s_q) begin
            w_state_d  = ST_IDLE;
            w_settle_d = '0;
            w_shift_d  = '0;
            w_freq_d   = '0;
            w_done_d   = 1'b0;
`ifdef FRINGE_REF_FRAMES_EN
            w_pix_d    = 2'b00;
`endif
        end else if (frame_stb) begin
            case (r_state_q)
                ST_IDLE: begin
                    w_state_d  = ST_SETTLE;
                    w_settle_d = '0;
                end
                ST_SETTLE: begin
                    if (r_rdy_s_q) begin
                        if (r_settle_q == c_settle_last) begin
`ifdef FRINGE_REF_FRAMES_EN
                            w_state_d = ST_REF_WHITE;
                            w_pix_d   = 2'b10;
`else
                            w_state_d = ST_EXPOSE;
                            w_shift_d = '0;
                            w_freq_d  = '0;
`endif
                            w_fire    = 1'b1;
                        end else begin
                            w_settle_d = r_settle_q + 1'b1;
                        end
                    end
                end
`ifdef FRINGE_REF_FRAMES_EN
                ST_REF_WHITE: begin
                    if (r_rdy_s_q) begin
                        w_state_d = ST_REF_BLACK;
                        w_pix_d   = 2'b01;
                        w_fire    = 1'b1;
                    end
                end
                ST_REF_BLACK: begin
                    if (r_rdy_s_q) begin
                        w_state_d = ST_EXPOSE;
                        w_pix_d   = 2'b00;
                        w_shift_d = '0;
                        w_freq_d  = '0;
                        w_fire    = 1'b1;
                    end
                end
`endif
                ST_EXPOSE: begin
                    if (r_rdy_s_q) begin
                        if (r_shift_q == c_shift_last) begin
                            if (r_freq_q == c_freq_last) begin
                                w_state_d = ST_DONE;
                                w_done_d  = 1'b1;
                            end else begin
                                w_shift_d = '0;
                                w_freq_d  = r_freq_q + 1'b1;
                                w_fire    = 1'b1;
                            end
                        end else begin
                            w_shift_d = r_shift_q + 1'b1;
                            w_fire    = 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    w_state_d = ST_DONE;
                end
                default: begin
                    w_state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Trigger pulse: a qualifying frame arriving mid-pulse is not retriggered.
    always_comb begin
        w_cam_d  = r_cam_q;
        w_tcnt_d = r_tcnt_q;
        if (!r_trig_s_q) begin
            w_cam_d  = 1'b0;
            w_tcnt_d = '0;
        end else if (r_cam_q) begin
            if (r_tcnt_q == '0) begin
                w_cam_d = 1'b0;
            end else begin
                w_tcnt_d = r_tcnt_q - 1'b1;
            end
        end else if (w_fire) begin
            w_cam_d  = 1'b1;
            w_tcnt_d = c_tcnt_load;
        end
    end

    // Phase shift n maps to n/NSTEP of a full turn in the top bits.
    always_comb begin
        w_pinc    = PINC0 >> r_freq_q;
        w_poff    = {r_shift_q, {(PW - c_sw){1'b0}}};
        w_phase_d = r_acc_q[PW-1 -: OW];
        if (row_stb) begin
            w_acc_d = w_poff;
        end else if (line_stb) begin
            w_acc_d = r_acc_q + w_pinc;
        end else begin
            w_acc_d = r_acc_q;
        end
    end

    always_ff @(posedge clk_25 or negedge reset_n) begin
        if (!reset_n) begin
            r_trig_meta_q <= 1'b0;
            r_trig_s_q    <= 1'b0;
            r_rdy_meta_q  <= 1'b0;
            r_rdy_s_q     <= 1'b0;
            r_state_q     <= ST_IDLE;
            r_settle_q    <= '0;
            r_shift_q     <= '0;
            r_freq_q      <= '0;
            r_done_q      <= 1'b0;
            r_cam_q       <= 1'b0;
            r_tcnt_q      <= '0;
`ifdef FRINGE_REF_FRAMES_EN
            r_pix_q       <= 2'b00;
`endif
            r_acc_q       <= '0;
            r_phase_q     <= '0;
        end else begin
            r_trig_meta_q <= trig_in;
            r_trig_s_q    <= r_trig_meta_q;
            r_rdy_meta_q  <= rdy_in;
            r_rdy_s_q     <= r_rdy_meta_q;
            r_state_q     <= w_state_d;
            r_settle_q    <= w_settle_d;
            r_shift_q     <= w_shift_d;
            r_freq_q      <= w_freq_d;
            r_done_q      <= w_done_d;
            r_cam_q       <= w_cam_d;
            r_tcnt_q      <= w_tcnt_d;
`ifdef FRINGE_REF_FRAMES_EN
            r_pix_q       <= w_pix_d;
`endif
            r_acc_q       <= w_acc_d;
            r_phase_q     <= w_phase_d;
        end
    end

    assign cam_trig  = r_cam_q;
    assign seq_busy  = (r_state_q == ST_IDLE) ? r_trig_s_q : 1'b1;
    assign done      = r_done_q;
    assign shift_idx = r_shift_q;
    assign freq_idx  = r_freq_q;
    assign phase_out = r_phase_q;
`ifdef FRINGE_REF_FRAMES_EN
    assign pix_force = r_pix_q;
`else
    assign pix_force = 2'b00;
`endif

endmodule
`default_nettype wire
